// File: rtl/fir_feeder.sv
// Feeds buffered 8-bit samples to an external FIR one at a time.
// Each FIR result is captured on the rising edge of fir_done, and a FIR that never completes is aborted after a timeout.
module fir_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [7:0]  in_data,
  output logic               in_ready,
  output logic signed [7:0]  fir_x,
  output logic               fir_start,
  input  logic               fir_done,
  input  logic signed [15:0] fir_y,
  output logic               out_valid,
  output logic signed [15:0] out_data,
  input  logic               out_ready,
  output logic [15:0]        sample_cnt,
  output logic               err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state;
  logic signed [7:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count;
  logic [TW-1:0]     tcnt;
  logic              done_q;
  logic              push, pop;

  assign in_ready = !rst && (count < FULL);
  assign push     = in_valid && in_ready;
  // Popping only when the result slot is free or draining means a capture never overwrites an unconsumed result.
  assign pop      = (state == S_IDLE) && (count != '0) && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      fir_x      <= '0;
      fir_start  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      sample_cnt <= '0;
      err        <= 1'b0;
      tcnt       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q    <= fir_done;
      fir_start <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            fir_x     <= mem[rptr];
            fir_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Only a fresh edge counts, so a done level left over from the previous operation is ignored.
          if (fir_done && !done_q) begin
            out_data   <= fir_y;
            out_valid  <= 1'b1;
            sample_cnt <= sample_cnt + 1'b1;
            state      <= S_IDLE;
          end else if (tcnt == TLAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_feeder.sv
// Directed bench for fir_feeder against a 4-tap FIR model with coefficients 1,2,3,4.
// The model's done output is a level that stays high until the next start.
module tb_fir_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [7:0] in_data = '0;
  logic out_ready = 1'b0;
  logic in_ready, fir_start, fir_done, out_valid, err;
  logic signed [7:0] fir_x;
  logic signed [15:0] fir_y, out_data;
  logic [15:0] sample_cnt;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fir_feeder #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fir_x(fir_x), .fir_start(fir_start),
    .fir_done(fir_done), .fir_y(fir_y), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .sample_cnt(sample_cnt),
    .err(err)
  );

  // FIR model: y = x + 2*x[-1] + 3*x[-2] + 4*x[-3], done rises 4 cycles after start
  logic model_clr = 1'b1, never_done = 1'b0, done_force = 1'b0, mdone = 1'b0;
  int h0 = 0, h1 = 0, h2 = 0, dly = 0;
  logic signed [15:0] my = '0, ypend = '0;
  assign fir_done = mdone | done_force;
  assign fir_y    = my;

  always @(posedge clk) begin
    if (model_clr) begin
      h0 <= 0; h1 <= 0; h2 <= 0; dly <= 0; mdone <= 1'b0; my <= '0;
    end else if (fir_start) begin
      ypend <= 16'(int'(fir_x) + 2*h0 + 3*h1 + 4*h2);
      h2 <= h1; h1 <= h0; h0 <= int'(fir_x);
      mdone <= 1'b0;
      dly <= 3;
    end else if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1 && !never_done) begin
        mdone <= 1'b1;
        my    <= ypend;
      end
    end
  end

  logic signed [15:0] got [$];
  always @(negedge clk) if (!rst && out_valid && out_ready) got.push_back(out_data);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; model_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    never_done = 1'b0; done_force = 1'b0;
    repeat (2) step();
    rst = 1'b0; model_clr = 1'b0;
    got.delete();
  endtask

  task automatic push(input logic signed [7:0] x, input int budget, output bit ok);
    in_valid = 1'b1; in_data = x; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; model_clr = 1'b1; in_valid = 1'b1; in_data = 8'sd9;
    out_ready = 1'b1; done_force = 1'b1;
    repeat (3) step();
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tests++; if ({fir_start, out_valid, err} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {fir_start, out_valid, err}); end
    tests++; if (fir_x !== 8'sd0 || out_data !== 16'sd0) begin fails++; $display("FAIL reset_data fir_x %0d out_data %0d want 0 0", fir_x, out_data); end
    tests++; if (sample_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", sample_cnt); end
    step();
    rst = 1'b0; model_clr = 1'b0; in_valid = 1'b0; done_force = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
    repeat (4) step();
    @(negedge clk);
    tests++; if (fir_start !== 1'b0 || sample_cnt !== 16'd0) begin fails++; $display("FAIL reset_fifo_empty start %b cnt %0d want 0 0", fir_start, sample_cnt); end
  endtask

  task automatic test_stream();
    logic signed [7:0] xs [5] = '{8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd0};
    logic signed [15:0] ex [5] = '{16'sd5, 16'sd16, 16'sd34, 16'sd60, 16'sd61};
    bit ok, all_ok;
    do_reset();
    out_ready = 1'b1; all_ok = 1'b1;
    foreach (xs[i]) begin push(xs[i], 50, ok); all_ok &= ok; end
    tests++; if (!all_ok) begin fails++; $display("FAIL stream_push_accept got 0 want 1"); end
    for (int i = 0; i < 200 && got.size() < 5; i++) step();
    repeat (10) step();
    tests++; if (got.size() != 5) begin fails++; $display("FAIL stream_count got %0d want 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      tests++; if (got[i] !== ex[i]) begin fails++; $display("FAIL stream_y%0d got %0d want %0d", i, got[i], ex[i]); end
    end
    tests++; if (sample_cnt !== 16'd5 || err !== 1'b0) begin fails++; $display("FAIL stream_cnt_err cnt %0d err %b want 5 0", sample_cnt, err); end
  endtask

  task automatic test_latency();
    bit bad, seen;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'sd5;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lat_accept got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    tests++; if (fir_start !== 1'b0) begin fails++; $display("FAIL lat_t1_start got %b want 0", fir_start); end
    @(negedge clk);
    tests++; if (fir_start !== 1'b1 || fir_x !== 8'sd5) begin fails++; $display("FAIL lat_t2_start start %b x %0d want 1 5", fir_start, fir_x); end
    bad = 1'b0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      if (fir_start !== 1'b0 || fir_x !== 8'sd5) bad = 1'b1;
    end
    tests++; if (bad) begin fails++; $display("FAIL lat_hold got unstable want start 0 x 5"); end
    tests++; if (!seen || out_data !== 16'sd5) begin fails++; $display("FAIL lat_result valid %b data %0d want 1 5", seen, out_data); end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] ex [6] = '{16'sd1, 16'sd4, 16'sd10, 16'sd20, 16'sd30, 16'sd40};
    bit ok, all_ok;
    do_reset();
    out_ready = 1'b0; all_ok = 1'b1;
    for (int i = 1; i <= 5; i++) begin push(8'(i), 20, ok); all_ok &= ok; end
    tests++; if (!all_ok) begin fails++; $display("FAIL bp_fill_accept got 0 want 1"); end
    repeat (20) step();
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b1 || out_data !== 16'sd1) begin fails++; $display("FAIL bp_held valid %b data %0d want 1 1", out_valid, out_data); end
    // done stays high the whole time the FSM is stalled
    in_valid = 1'b1; in_data = 8'sd6;
    repeat (60) step();
    @(negedge clk);
    tests++; if (sample_cnt !== 16'd1 || out_data !== 16'sd1 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall cnt %0d data %0d ready %b want 1 1 0", sample_cnt, out_data, in_ready); end
    step();
    out_ready = 1'b1;
    push(8'sd6, 50, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_sixth_accept got 0 want 1"); end
    for (int i = 0; i < 200 && got.size() < 6; i++) step();
    repeat (10) step();
    tests++; if (got.size() != 6) begin fails++; $display("FAIL bp_count got %0d want 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      tests++; if (got[i] !== ex[i]) begin fails++; $display("FAIL bp_y%0d got %0d want %0d", i, got[i], ex[i]); end
    end
    tests++; if (sample_cnt !== 16'd6) begin fails++; $display("FAIL bp_cnt got %0d want 6", sample_cnt); end
  endtask

  task automatic test_timeout();
    bit ok, started, vseen;
    int k;
    do_reset();
    out_ready = 1'b1; never_done = 1'b1;
    push(8'sd3, 20, ok);
    push(8'sd4, 20, ok);
    started = 1'b0;
    for (int i = 0; i < 10 && !started; i++) begin
      @(negedge clk);
      if (fir_start) started = 1'b1;
    end
    tests++; if (!started) begin fails++; $display("FAIL to_first_start got 0 want 1"); end
    k = 0; vseen = 1'b0;
    while (k < 70 && !err) begin
      @(negedge clk);
      k++;
      if (out_valid) vseen = 1'b1;
    end
    tests++; if (k != 65) begin fails++; $display("FAIL to_err_cycle got %0d want 65", k); end
    tests++; if (vseen || sample_cnt !== 16'd0) begin fails++; $display("FAIL to_discard valid %b cnt %0d want 0 0", vseen, sample_cnt); end
    @(negedge clk);
    tests++; if (fir_start !== 1'b1 || fir_x !== 8'sd4) begin fails++; $display("FAIL to_next_issue start %b x %0d want 1 4", fir_start, fir_x); end
  endtask

  task automatic test_reset_wait();
    bit ok, all_ok, bad;
    do_reset();
    out_ready = 1'b1; never_done = 1'b1; all_ok = 1'b1;
    push(8'sd10, 20, ok); all_ok &= ok;
    push(8'sd20, 20, ok); all_ok &= ok;
    push(8'sd30, 20, ok); all_ok &= ok;
    push(8'sd40, 20, ok); all_ok &= ok;
    tests++; if (!all_ok) begin fails++; $display("FAIL rw_push_accept got 0 want 1"); end
    rst = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'sd50;
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rw_rst_ready got %b want 0", in_ready); end
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tests++; if ({fir_start, out_valid, err, in_ready} !== 4'b0001 || fir_x !== 8'sd0 || sample_cnt !== 16'd0 || out_data !== 16'sd0) begin
      fails++; $display("FAIL rw_outputs start/valid/err/ready %b x %0d cnt %0d data %0d want 0001 0 0 0", {fir_start, out_valid, err, in_ready}, fir_x, sample_cnt, out_data);
    end
    repeat (3) step();
    done_force = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (fir_start || out_valid) bad = 1'b1;
    end
    tests++; if (bad || sample_cnt !== 16'd0) begin fails++; $display("FAIL rw_late_done activity %b cnt %0d want 0 0", bad, sample_cnt); end
    done_force = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_backpressure();
    test_timeout();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
